fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer_pkg.sv | 31 +++
 rtl/butterflyunit.sv | 31 +++
 rtl/fft_sequencer.sv | 158 +++++++++++++++
 tb/tb_fft_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sequencer_pkg.sv
// Shared definitions for the 16-point radix-2 FFT sequencer: state encoding,
// Q1.15 twiddle ROM and the address bit-reversal helper.
package fft_sequencer_pkg;

  localparam int NBFLY = 32;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  // W[k] = {cos(2*pi*k/16), -sin(2*pi*k/16)}, each half Q1.15 signed.
  localparam logic [31:0] W_ROM [8] = '{
    32'h7FFF_0000, 32'h7641_CF04, 32'h5A82_A57E, 32'h30FC_89BF,
    32'h0000_8000, 32'hCF04_89BF, 32'hA57E_A57E, 32'h89BF_CF04
  };

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic [31:0] half_cplx(input logic [31:0] z);
    logic signed [15:0] re;
    logic signed [15:0] im;
    re = z[31:16];
    im = z[15:0];
    return {re >>> 1, im >>> 1};
  endfunction

endpackage

// File: rtl/butterflyunit.sv
// Radix-2 DIT butterfly: A_f = A + W*B, B_f = A - W*B on {re,im} Q1.15 words.
// The complex product is rounded once to Q1.15; sums wrap in 16 bits.
module butterflyunit (
  input  logic [31:0] A_t,
  input  logic [31:0] B_t,
  input  logic [31:0] W,
  output logic [31:0] A_f,
  output logic [31:0] B_f
);

  localparam logic signed [32:0] RND = 33'sd16384;

  logic signed [15:0] ar, ai, br, bi, wr, wi;
  logic signed [32:0] prod_re, prod_im;
  logic signed [15:0] wb_re, wb_im;

  assign {ar, ai} = A_t;
  assign {br, bi} = B_t;
  assign {wr, wi} = W;

  // Full-precision products are combined before a single round-half-up.
  assign prod_re = 33'(wr) * 33'(br) - 33'(wi) * 33'(bi) + RND;
  assign prod_im = 33'(wr) * 33'(bi) + 33'(wi) * 33'(br) + RND;

  assign wb_re = 16'(prod_re >>> 15);
  assign wb_im = 16'(prod_im >>> 15);

  assign A_f = {ar + wb_re, ai + wb_im};
  assign B_f = {ar - wb_re, ai - wb_im};

endmodule

// File: rtl/fft_sequencer.sv
// 16-point in-place FFT: load bit-reversed samples, run 32 butterflies, stream
// bins in natural order. Define FFT_SEQUENCER_SCALE_EN to halve each stage.
module fft_sequencer
  import fft_sequencer_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NPTS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*DW-1:0] m_data,
  output logic [3:0]      m_index,
  output logic            m_last,
  output logic            busy,
  output logic            frame_done
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        m_index_q, m_index_d;
  logic [2*DW-1:0]   m_data_q, m_data_d;
  logic              frame_done_q, frame_done_d;

  logic [2*DW-1:0]   buf_q [NPTS];

  logic              wr_en_a, wr_en_b;
  logic [3:0]        wr_addr_a, wr_addr_b;
  logic [2*DW-1:0]   wr_data_a, wr_data_b;

  logic [3:0]        bf_a, bf_b;
  logic [2:0]        tw_k;
  logic [31:0]       a_f, b_f, a_wb, b_wb;

  // cnt_q = {stage[1:0], butterfly[2:0]}; bf_a and bf_b are h apart, h = 2^stage.
  always_comb begin
    bf_a = '0;
    tw_k = '0;
    case (cnt_q[4:3])
      2'd0:    begin bf_a = {cnt_q[2:0], 1'b0};              tw_k = 3'd0;                end
      2'd1:    begin bf_a = {cnt_q[2:1], 1'b0, cnt_q[0]};    tw_k = {cnt_q[0], 2'b00};   end
      2'd2:    begin bf_a = {cnt_q[2], 1'b0, cnt_q[1:0]};    tw_k = {cnt_q[1:0], 1'b0};  end
      default: begin bf_a = {1'b0, cnt_q[2:0]};              tw_k = cnt_q[2:0];          end
    endcase
    bf_b = bf_a | (4'd1 << cnt_q[4:3]);
  end

  butterflyunit u_bfly (
    .A_t (buf_q[bf_a]),
    .B_t (buf_q[bf_b]),
    .W   (W_ROM[tw_k]),
    .A_f (a_f),
    .B_f (b_f)
  );

`ifdef FFT_SEQUENCER_SCALE_EN
  assign a_wb = half_cplx(a_f);
  assign b_wb = half_cplx(b_f);
`else
  assign a_wb = a_f;
  assign b_wb = b_f;
`endif

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which is what keeps combinational logic from inferring latches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_index_d    = m_index_q;
    m_data_d     = m_data_q;
    frame_done_d = 1'b0;
    wr_en_a      = 1'b0;
    wr_en_b      = 1'b0;
    wr_addr_a    = bf_a;
    wr_addr_b    = bf_b;
    wr_data_a    = a_wb;
    wr_data_b    = b_wb;

    case (state_q)
      LOAD: begin
        if (s_valid) begin
          wr_en_a   = 1'b1;
          wr_addr_a = bitrev4(cnt_q[3:0]);
          wr_data_a = {s_data, 16'h0000};
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q[3:0] == 4'd15) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        wr_en_a = 1'b1;
        wr_en_b = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(NBFLY - 1)) begin
          // Bin 0 was finalised by the first stage-3 butterfly, so it is safe
          // to latch while the last butterfly writes entries 7 and 15.
          cnt_d     = '0;
          state_d   = UNLOAD;
          m_index_d = '0;
          m_data_d  = buf_q[0];
        end
      end
      UNLOAD: begin
        if (m_ready) begin
          if (m_index_q == 4'd15) begin
            state_d      = LOAD;
            m_index_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            m_index_d = m_index_q + 4'd1;
            m_data_d  = buf_q[m_index_q + 4'd1];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      m_index_q    <= '0;
      m_data_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_index_q    <= m_index_d;
      m_data_q     <= m_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the sample buffer has no reset; every entry is rewritten during LOAD
  // before it is read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en_a) buf_q[wr_addr_a] <= wr_data_a;
    if (wr_en_b) buf_q[wr_addr_b] <= wr_data_b;
  end

  assign s_ready    = (state_q == LOAD);
  assign m_valid    = (state_q == UNLOAD);
  assign m_data     = m_data_q;
  assign m_index    = m_index_q;
  assign m_last     = (state_q == UNLOAD) && (m_index_q == 4'd15);
  assign busy       = (state_q != LOAD);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: directed frame table, multi-cycle
// protocol sequences and random frames against a floating-point DFT model.
module tb_fft_sequencer;

`ifdef FFT_SEQUENCER_SCALE_EN
  localparam int GAIN_SHIFT = 4;
`else
  localparam int GAIN_SHIFT = 0;
`endif
  localparam real PI  = 3.14159265358979323846;
  localparam int  TOL = 2;

  typedef logic [15:0][15:0] frame_t;
  typedef logic [15:0][31:0] bins_t;
  typedef struct {
    logic [63:0] name;
    frame_t      x;
    bins_t       y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, m_last, busy, frame_done;
  logic [31:0] m_data;
  logic [3:0]  m_index;

  int n_checks = 0;
  int n_errors = 0;
  real model_re [16];
  real model_im [16];

  fft_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint rnd(input real r);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  // Direct O(N^2) DFT, independent of butterfly ordering.
  function automatic void dft(input frame_t x);
    real sr, si, xv, ang;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        xv  = real'($signed(x[n]));
        ang = 2.0 * PI * real'(k * n) / 16.0;
        sr  = sr + xv * $cos(ang);
        si  = si - xv * $sin(ang);
      end
      model_re[k] = sr / real'(1 << GAIN_SHIFT);
      model_im[k] = si / real'(1 << GAIN_SHIFT);
    end
  endfunction

  task automatic cmp_table(input string tag, input bins_t y, input bins_t exp_y);
    int er, ei;
    for (int k = 0; k < 16; k++) begin
      er = $signed(exp_y[k][31:16]);
      ei = $signed(exp_y[k][15:0]);
      er = er >>> GAIN_SHIFT;
      ei = ei >>> GAIN_SHIFT;
      check($sformatf("%s bin%0d re", tag, k), longint'($signed(y[k][31:16])), er, TOL);
      check($sformatf("%s bin%0d im", tag, k), longint'($signed(y[k][15:0])), ei, TOL);
    end
  endtask

  task automatic cmp_model(input string tag, input bins_t y);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s bin%0d re", tag, k), longint'($signed(y[k][31:16])), rnd(model_re[k]), TOL);
      check($sformatf("%s bin%0d im", tag, k), longint'($signed(y[k][15:0])), rnd(model_im[k]), TOL);
    end
  endtask

  // mode 0: plain; 1: random s_valid/m_ready; 2: m_ready low 5 cycles on bin 3;
  // 3: s_valid held high through COMPUTE and UNLOAD.
  task automatic run_frame(input frame_t x, input int mode, output bins_t y);
    int n, guard, waited, j, stall, early, fd_seen, bad_ready;
    bit hs;
    logic [31:0] held;
    y = '0;
    held = '0;
    n = 0; guard = 0; early = 0;
    while (n < 16 && guard < 400) begin
      s_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = x[n];
      if (m_valid) early++;
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) n++;
    end
    check("load_samples", n, 16, 0);

    s_valid = (mode == 3);
    s_data  = 16'hDEAD;
    waited = 0;
    while (!m_valid && waited < 64) begin
      if (waited == 5) begin
        check("busy_in_compute", busy, 1, 0);
        check("s_ready_in_compute", s_ready, 0, 0);
      end
      @(posedge clk); #1;
      waited++;
    end
    check("m_valid_latency", waited, 32, 0);
    check("m_valid_during_load", early, 0, 0);

    j = 0; guard = 0; stall = 0; fd_seen = 0; bad_ready = 0;
    while (j < 16 && guard < 400) begin
      case (mode)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = !(j == 3 && stall < 5);
        default: m_ready = 1'b1;
      endcase
      if (mode == 3) begin
        s_valid = 1'b1;
        s_data  = 16'($urandom);
      end
      if (s_ready) bad_ready++;
      if (frame_done) fd_seen++;
      if (mode == 2 && j == 3) begin
        if (stall == 0) held = m_data;
        else begin
          check("bp_hold_data", m_data, held, 0);
          check("bp_hold_index", m_index, 3, 0);
        end
        if (!m_ready) stall++;
      end
      hs = m_valid && m_ready;
      if (hs) begin
        check($sformatf("bin%0d_index", j), m_index, j, 0);
        check($sformatf("bin%0d_last", j), m_last, (j == 15) ? 1 : 0, 0);
        y[j] = m_data;
        j++;
      end
      @(posedge clk); #1;
      guard++;
    end
    check("bins_delivered", j, 16, 0);
    check("s_ready_in_unload", bad_ready, 0, 0);
    check("frame_done_early", fd_seen, 0, 0);
    check("frame_done_pulse", frame_done, 1, 0);
    check("s_ready_after_frame", s_ready, 1, 0);
    check("m_valid_after_frame", m_valid, 0, 0);
    check("busy_after_frame", busy, 0, 0);
    m_ready = 1'b0;
    if (mode != 3) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
      check("frame_done_once", frame_done, 0, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " s_ready"}, s_ready, 1, 0);
    check({tag, " m_valid"}, m_valid, 0, 0);
    check({tag, " m_data"}, m_data, 0, 0);
    check({tag, " m_index"}, m_index, 0, 0);
    check({tag, " m_last"}, m_last, 0, 0);
    check({tag, " busy"}, busy, 0, 0);
    check({tag, " frame_done"}, frame_done, 0, 0);
  endtask

  initial begin
    vec_t  vecs [3];
    bins_t y;
    frame_t xr;
    int v;

    vecs[0].name = "impulse";
    vecs[1].name = "dc";
    vecs[2].name = "altern";
    for (int i = 0; i < 3; i++) begin
      vecs[i].x = '0;
      vecs[i].y = '0;
    end
    vecs[0].x[0] = 16'h4000;
    for (int k = 0; k < 16; k++) vecs[0].y[k] = 32'h4000_0000;
    for (int n = 0; n < 16; n++) vecs[1].x[n] = 16'h0400;
    vecs[1].y[0] = 32'h4000_0000;
    for (int n = 0; n < 16; n++) vecs[2].x[n] = n[0] ? 16'hFC00 : 16'h0400;
    vecs[2].y[8] = 32'h4000_0000;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_frame(vecs[i].x, 0, y);
      cmp_table($sformatf("%s", vecs[i].name), y, vecs[i].y);
    end

    run_frame(vecs[0].x, 2, y);
    cmp_table("backpressure", y, vecs[0].y);

    run_frame(vecs[2].x, 3, y);
    cmp_table("protocol_a", y, vecs[2].y);
    run_frame(vecs[1].x, 3, y);
    cmp_table("protocol_b", y, vecs[1].y);
    s_valid = 1'b0;

    // Abort a frame ten cycles into COMPUTE, then run a fresh impulse frame.
    for (int n = 0; n < 16; n++) begin
      s_valid = 1'b1;
      s_data  = 16'h0400;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset s_ready", s_ready, 1, 0);
    check("midreset m_valid", m_valid, 0, 0);
    check("midreset busy", busy, 0, 0);
    check("midreset m_index", m_index, 0, 0);
    run_frame(vecs[0].x, 0, y);
    cmp_table("after_reset", y, vecs[0].y);

    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 16; n++) begin
        v = int'($urandom_range(0, 1023)) - 512;
        xr[n] = 16'(v);
      end
      dft(xr);
      run_frame(xr, 1, y);
      cmp_model($sformatf("random%0d", f), y);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
